// File: rtl/block_chunk_serializer_if.sv
// Handshake bundle for block_chunk_serializer: block input side and chunk output side.
// The slave modport is the serializer's view; master is the producer/consumer environment.
interface block_chunk_serializer_if #(
    parameter int unsigned BLOCK_W = 512,
    parameter int unsigned CHUNK_W = 4
);
    localparam int unsigned N  = BLOCK_W / CHUNK_W;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] message_input;
    logic               out_valid;
    logic               out_ready;
    logic [CHUNK_W-1:0] data_out;
    logic [IW-1:0]      out_index;
    logic               out_last;

    modport master (
        output in_valid, message_input, out_ready,
        input  in_ready, out_valid, data_out, out_index, out_last
    );

    modport slave (
        input  in_valid, message_input, out_ready,
        output in_ready, out_valid, data_out, out_index, out_last
    );
endinterface

// File: rtl/block_chunk_serializer.sv
// Latches one BLOCK_W message block and streams it out as N = BLOCK_W/CHUNK_W chunks,
// LSB-chunk-first or MSB-chunk-first, with index and last flag. Supports back-to-back
// blocks with no bubble, output backpressure, and a synchronous flush.
module block_chunk_serializer #(
    parameter int unsigned BLOCK_W   = 512,
    parameter int unsigned CHUNK_W   = 4,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    output logic                     busy,
    block_chunk_serializer_if.slave  bus
);
    localparam int unsigned N  = BLOCK_W / CHUNK_W;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(N - 1);

    typedef enum logic {StIdle, StSend} state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      cnt_q, cnt_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;

    // Chunk view of the holding register; chunk k sits at bits [k*CHUNK_W +: CHUNK_W].
    logic [N-1:0][CHUNK_W-1:0] chunks;
    logic [IW-1:0]             sel;
    logic                      send;
    logic                      last;
    logic                      accept;

    assign chunks = blk_q;

    // Outputs depend on registered state only, except in_ready which looks at out_ready/flush.
    always_comb begin
        send          = (state_q == StSend);
        last          = send && (cnt_q == LastIdx);
        sel           = MSB_FIRST ? (LastIdx - cnt_q) : cnt_q;
        bus.out_valid = send;
        bus.out_last  = last;
        bus.out_index = send ? cnt_q : '0;
        bus.data_out  = send ? chunks[sel] : '0;
        busy          = send;
        if (flush) begin
            bus.in_ready = 1'b0;
        end else if (!send) begin
            bus.in_ready = 1'b1;
        end else begin
            bus.in_ready = last && bus.out_ready;
        end
        accept = bus.in_valid && bus.in_ready;
    end

    // Next-state: flush beats acceptance, acceptance beats a plain output beat.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
            blk_d   = '0;
        end else if (accept) begin
            state_d = StSend;
            cnt_d   = '0;
            blk_d   = bus.message_input;
        end else if (send && bus.out_ready) begin
            if (last) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + IW'(1);
            end
        end
    end

    // State, counter and holding register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
        end
    end
endmodule

// File: doc/block_chunk_serializer.md
# block_chunk_serializer

Parametrised, sequential successor to the combinational block-to-nibble splitter. It accepts one BLOCK_W-bit message block through a valid/ready handshake and emits it as BLOCK_W/CHUNK_W chunks of CHUNK_W bits, one per accepted output beat, in a configurable order. Each chunk carries an index and a last flag. It sits between the message-padding stage and any chunk-serial consumer, such as a word scheduler or a debug/UART path, in the SHA-256 datapath.

## Interface
- BLOCK_W, 512, width of an input message block; must be a multiple of CHUNK_W.
- CHUNK_W, 4, width of one output chunk (4 = nibble, 8 = byte, 32 = SHA word).
- MSB_FIRST, 0, chunk order:
  - 0: chunk k = block[k*CHUNK_W +: CHUNK_W].
  - 1: chunk k = block[BLOCK_W-1-k*CHUNK_W -: CHUNK_W].
- Derived: N = BLOCK_W/CHUNK_W; IW = max(1, $clog2(N)).
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- flush  input  1  synchronous abort of the block in progress.
- in_valid  input  1  message_input holds a valid block.
- in_ready  output  1  block will be accepted this cycle if in_valid is high.
- message_input  input  BLOCK_W  message block.
- out_valid  output  1  data_out, out_index and out_last are valid.
- out_ready  input  1  consumer accepts the current chunk.
- data_out  output  CHUNK_W  current chunk.
- out_index  output  IW  index k of the current chunk, 0..N-1.
- out_last  output  1  high when out_index == N-1 and out_valid is high.
- busy  output  1  a block is held (state SEND).

## Operation
- Two states, IDLE and SEND. The block is latched into a BLOCK_W holding register and a chunk counter cnt (IW bits) selects the output chunk.
- IDLE:
  - in_ready = !flush.
  - On in_valid && in_ready: latch the block, set cnt = 0, go to SEND.
- SEND:
  - out_valid = 1; data_out = chunk cnt; out_index = cnt; out_last = (cnt == N-1).
- Output beat = out_valid && out_ready.
  - On a beat with cnt < N-1: cnt increments.
  - On a beat with cnt == N-1: the block is complete.
- Back-to-back blocks: in SEND, in_ready = out_last && out_ready && !flush. If in_valid is also high, the new block is latched, cnt = 0, and the state stays SEND, so there is no bubble. Otherwise the state goes to IDLE.
- Backpressure: while out_valid && !out_ready, data_out, out_index, out_last and cnt hold.
- The holding register is written only on input acceptance; message_input may change freely after the handshake.
- flush (when rst_n is high):
  - Next state is IDLE, cnt = 0, the held block is discarded.
  - in_ready is low in the flush cycle, so no block is accepted.
  - A beat presented in the flush cycle is still valid to the consumer. The remaining chunks are dropped.
- N == 1: every beat is also last; the back-to-back rule still applies.
- cnt never wraps past N-1.

## Timing
- Reset (rst_n low at a rising edge) forces:
  - state = IDLE, cnt = 0, holding register = 0.
  - out_valid = 0, out_last = 0, out_index = 0, data_out = 0, busy = 0.
- Reset priority: rst_n > flush > handshakes.
- The block is in reset in any cycle sampled with rst_n low. in_ready is combinationally 1 in IDLE when flush is low, including during reset, but no acceptance takes effect while rst_n is low.
- Latency: a block accepted at edge E presents chunk 0 in the cycle after E.
- Throughput: with out_ready held high, one block every N cycles with continuous back-to-back input.
- in_ready depends combinationally on out_ready and flush. out_valid, data_out, out_index and out_last are registered-state functions only (no combinational path from inputs).
- Reset mid-block: takes effect at the next edge. out_valid is low the following cycle. No partial chunk is emitted afterwards.

## Test plan
- Reset values: hold rst_n = 0 for 3 cycles with in_valid = 1 -> out_valid = 0, busy = 0, data_out = 0; no block accepted.
- Default parameters, streaming: block with nibble i = i mod 16 (512'hFEDC…3210), out_ready = 1 -> 128 beats carrying 0,1,…,F repeating; out_index 0..127; out_last only on beat 127; busy falls 1 cycle later.
- Backpressure and back-to-back:
  - Toggle out_ready randomly -> every beat in order; outputs stable while stalled.
  - Second block 512'h5…5 offered during the last beat -> accepted on that edge, first chunk 4'h5 on the next cycle, no idle cycle.
- MSB_FIRST = 1, CHUNK_W = 32, BLOCK_W = 512 on the same 512'hFEDC…3210 block -> 16 beats; first 32'hFEDCBA98, second 32'h76543210, last 32'h76543210; out_last on beat 15.
- Flush at chunk 40 (in_valid high in the same cycle) -> beat 40 delivered, nothing accepted that cycle, out_valid = 0 next cycle, IDLE; a new block then starts at index 0.
- Reset mid-block at chunk 10 -> out_valid = 0 and all outputs 0 on the next cycle; the following block streams normally from index 0.
